// File: rtl/hack_clk_pkg.sv
// Shared types and constants for the strobe monitor block.
package hack_clk_pkg;

  localparam int CNT_W        = 8;
  localparam int EXPECTED_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-register rising-edge detector; a level held high gives one rise.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic rise
);

  logic in_d;

  // Delay the input by one clk for edge comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_d <= 1'b0;
    else        in_d <= in;
  end

  assign rise = in & ~in_d;

endmodule

// File: rtl/strobe_monitor.sv
// Measures the period of a clk-synchronous strobe, declares lock after a run
// of matching periods, and flags/counts mismatches and strobe loss.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | no strobe history; waiting for a first rise
//   ST_MEASURE | counting consecutive matching periods toward lock
//   ST_LOCKED  | strobe period stable; mismatch or loss raises err
//
// The rise feeds only registers, so no output depends combinationally on strobe.
module strobe_monitor
  import hack_clk_pkg::*;
#(
  parameter int EXPECTED = EXPECTED_DEF,
  parameter int LOCK_N   = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strobe,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] EXP_C  = CNT_W'(EXPECTED);
  localparam logic [CNT_W-1:0] LOCK_C = CNT_W'(LOCK_N);
  localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(TIMEOUT);

  state_t           state, state_nxt;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] good, good_nxt, good_inc;
  logic             load_period;
  logic             err_nxt;

  rise_detect u_rise (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (strobe),
    .rise (rise)
  );

  assign good_inc = good + 8'd1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-rise decisions; a rise always wins over a timeout.
  always_comb begin
    state_nxt   = state;
    good_nxt    = good;
    load_period = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        // First rise only starts the gap count; its period is meaningless.
        if (rise) begin
          state_nxt = ST_MEASURE;
          good_nxt  = '0;
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          load_period = 1'b1;
          if (cnt == EXP_C) begin
            good_nxt = good_inc;
            if (good_inc == LOCK_C) state_nxt = ST_LOCKED;
          end else begin
            good_nxt = '0;
          end
        end else if (cnt == TMO_C) begin
          state_nxt = ST_IDLE;
          good_nxt  = '0;
        end
      end
      ST_LOCKED: begin
        if (rise) begin
          load_period = 1'b1;
          if (cnt != EXP_C) begin
            err_nxt   = 1'b1;
            state_nxt = ST_MEASURE;
            good_nxt  = '0;
          end
        end else if (cnt == TMO_C) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
          good_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        good_nxt  = '0;
      end
    endcase
  end

  // Lock indication straight from the state register.
  always_comb begin
    locked = (state == ST_LOCKED);
  end

  // Gap counter, match counter, period capture and the err pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      good   <= '0;
      period <= '0;
      err    <= 1'b0;
    end else begin
      cnt    <= rise ? 8'd1 : sat_inc(cnt);
      good   <= good_nxt;
      err    <= err_nxt;
      if (load_period) period <= cnt;
    end
  end

  // Fault counter; a clear landing on an err pulse still counts that pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     err_count <= '0;
    else if (clear) err_count <= err ? 8'd1 : 8'd0;
    else if (err)   err_count <= sat_inc(err_count);
  end

endmodule

// File: tb/tb_strobe_monitor.sv
// Directed bench for strobe_monitor with hand-computed expectations.
module tb_strobe_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       strobe;
  logic       clear;
  logic [7:0] period;
  logic       locked;
  logic       err;
  logic [7:0] err_count;

  int total = 0;
  int bad   = 0;
  int err_seen = 0;
  int exp_ec = 0;
  int seen0;

  strobe_monitor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .strobe   (strobe),
    .clear    (clear),
    .period   (period),
    .locked   (locked),
    .err      (err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Count err pulses seen on the falling edge, away from the active edge.
  always @(negedge clk) if (err) err_seen++;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic s);
    strobe = s;
    @(posedge clk);
    #1;
  endtask

  // Gap of n cycles ending in a rise: n-1 low cycles then one high cycle.
  task automatic gap(input int n);
    for (int i = 0; i < n - 1; i++) tick(1'b0);
    tick(1'b1);
  endtask

  task automatic do_reset();
    strobe = 1'b0;
    clear  = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic lock_up();
    for (int i = 0; i < 5; i++) gap(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    strobe = 1'b0;
    clear  = 1'b0;
    #3;
    chk("rst_period", period, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_errcnt", err_count, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal 0,0,1 strobe: period from 2nd rise, lock after 5th.
    gap(3);
    chk("r1_period", period, 0);
    chk("r1_locked", locked, 0);
    gap(3);
    chk("r2_period", period, 3);
    gap(3); gap(3);
    chk("r4_locked", locked, 0);
    gap(3);
    chk("r5_locked", locked, 1);
    chk("nominal_noerr", err_seen, 0);

    // One long gap while locked.
    gap(4);
    chk("g4_err", err, 1);
    chk("g4_locked", locked, 0);
    chk("g4_period", period, 4);
    exp_ec = 1;
    gap(3);
    chk("g4_err_off", err, 0);
    chk("g4_errcnt", err_count, exp_ec);
    gap(3); gap(3);
    chk("relock_early", locked, 0);
    gap(3);
    chk("relock", locked, 1);

    // Strobe stuck low: timeout at cnt == 16.
    seen0 = err_seen;
    for (int i = 0; i < 15; i++) tick(1'b0);
    chk("stk0_pre_err", err, 0);
    chk("stk0_pre_lock", locked, 1);
    tick(1'b0);
    chk("stk0_err", err, 1);
    chk("stk0_locked", locked, 0);
    chk("stk0_period", period, 3);
    exp_ec++;
    for (int i = 0; i < 40; i++) tick(1'b0);
    chk("stk0_once", err_seen - seen0, 1);
    chk("stk0_errcnt", err_count, exp_ec);

    // Strobe stuck high: same timeout behaviour.
    lock_up();
    chk("stk1_lock", locked, 1);
    seen0 = err_seen;
    for (int i = 0; i < 15; i++) tick(1'b1);
    chk("stk1_pre_err", err, 0);
    tick(1'b1);
    chk("stk1_err", err, 1);
    chk("stk1_locked", locked, 0);
    chk("stk1_period", period, 3);
    exp_ec++;
    for (int i = 0; i < 40; i++) tick(1'b1);
    chk("stk1_once", err_seen - seen0, 1);
    chk("stk1_errcnt", err_count, exp_ec);

    // Asynchronous reset between clk edges while locked.
    lock_up();
    chk("ar_locked_pre", locked, 1);
    seen0 = err_seen;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_locked", locked, 0);
    chk("ar_err", err, 0);
    chk("ar_period", period, 0);
    chk("ar_errcnt", err_count, 0);
    strobe = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    gap(3);
    chk("ar_entry_period", period, 0);
    gap(3);
    chk("ar_second_period", period, 3);
    chk("ar_noerr", err_seen - seen0, 0);

    // Alternating 2/4 gaps never lock.
    do_reset();
    seen0 = err_seen;
    gap(2);
    for (int i = 0; i < 4; i++) begin
      gap(4);
      chk("alt_p4", period, 4);
      gap(2);
      chk("alt_p2", period, 2);
      chk("alt_locked", locked, 0);
    end
    chk("alt_noerr", err_seen - seen0, 0);

    // 300 faults saturate the counter; then clear on an err pulse.
    do_reset();
    lock_up();
    for (int k = 1; k <= 300; k++) begin
      gap(4);
      for (int i = 0; i < 4; i++) gap(3);
      if (k == 100) chk("sat_mid", err_count, 100);
    end
    chk("sat_full", err_count, 255);
    chk("sat_locked", locked, 1);
    gap(4);
    chk("clr_err", err, 1);
    clear = 1'b1;
    tick(1'b0);
    clear = 1'b0;
    chk("clr_coincide", err_count, 1);
    clear = 1'b1;
    tick(1'b0);
    clear = 1'b0;
    chk("clr_plain", err_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/strobe_monitor.md
STROBE_MONITOR -- requirements
Module: strobe_monitor

Interface
REQ-001 Parameter EXPECTED, default 3, meaning the required clk cycles between strobe rising edges (3 = 100 MHz / 33.33 MHz Hack clock).
REQ-002 Parameter LOCK_N, default 4, meaning consecutive matching periods needed to declare lock; legal range 1..255.
REQ-003 Parameter TIMEOUT, default 16, meaning the gap count that declares strobe loss; SHALL satisfy EXPECTED < TIMEOUT <= 255.
REQ-004 clk  in  1  single system clock (100 MHz); all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 strobe  in  1  divided clock/enable under test, synchronous to clk.
REQ-007 clear  in  1  synchronous clear of err_count.
REQ-008 period  out  8  last measured rising-edge-to-rising-edge gap, in clk cycles.
REQ-009 locked  out  1  high while the FSM is in LOCKED.
REQ-010 err  out  1  single-cycle pulse per detected fault.
REQ-011 err_count  out  8  saturating fault counter.

Function
REQ-012 strobe_d SHALL register strobe; rise = strobe & ~strobe_d; a strobe held high yields exactly one rise.
REQ-013 Gap counter cnt (8 bit) SHALL load 1 on rise, else increment, saturating at 255.
REQ-014 On rise, period SHALL load cnt, so a strobe pattern 0,0,1 repeating gives period = 3.
REQ-015 The FSM states SHALL be IDLE, MEASURE, and LOCKED.
REQ-016 IDLE: on rise, go to MEASURE with good = 0; period SHALL NOT update on this first rise.
REQ-017 MEASURE: on rise, if cnt == EXPECTED then increment good, else set good = 0 without raising err.
REQ-018 MEASURE: when a matching rise brings good to LOCK_N, go to LOCKED.
REQ-019 MEASURE: if cnt == TIMEOUT with no rise in that cycle, go to IDLE without raising err.
REQ-020 LOCKED: a rise with cnt != EXPECTED SHALL pulse err and go to MEASURE with good = 0.
REQ-021 LOCKED: cnt == TIMEOUT with no rise SHALL pulse err and go to IDLE.
REQ-022 Latency: period, locked, and err SHALL be registered and visible the cycle after the edge that samples the rise or timeout.
REQ-023 err_count SHALL increment on each err pulse and saturate at 255.
REQ-024 clear SHALL set err_count to 0; when clear and err coincide, err_count SHALL become 1.
REQ-025 A rise and cnt == TIMEOUT in the same cycle SHALL be treated as a rise, not a timeout.

Reset
REQ-026 While rst_n = 0, the following SHALL hold immediately, independent of clk: state = IDLE, strobe_d = 0, cnt = 0, good = 0, period = 0, locked = 0, err = 0, err_count = 0.
REQ-027 Reset asserted mid-operation, including in LOCKED, SHALL discard all history; no err is generated by reset or by its release.
REQ-028 After rst_n rises, the first rise SHALL behave as the IDLE entry rise.

Structure
REQ-029 Shared package hack_clk_pkg SHALL hold the FSM state typedef, the counter width constant (8), and the default EXPECTED value.
REQ-030 Rising-edge detection SHALL be one sub-module, rise_detect (clk, rst_n, in, rise).
REQ-031 The block SHALL contain no combinational path from strobe to any output.

Verification
REQ-032 Reset, then strobe 0,0,1 repeating -> period = 3 from the 2nd rise; locked = 1 the cycle after the 5th rise; err never asserted.
REQ-033 Locked, then one gap of 4 -> err pulses for 1 cycle, err_count = 1, locked = 0; locked returns after 4 further gaps of 3.
REQ-034 Locked, then strobe stuck 0 (also repeat with strobe stuck 1) -> err pulses once when cnt reaches 16; state = IDLE, locked = 0, period holds 3.
REQ-035 Alternate 2- and 4-cycle gaps from reset -> locked never rises, err never pulses; period alternates between 2 and 4.
REQ-036 Force 300 faults -> err_count saturates at 255; then clear coinciding with an err pulse -> err_count = 1.
REQ-037 Assert rst_n low asynchronously mid-LOCKED, between clk edges -> locked, err, period, and err_count all read 0 before the next clk edge.
